servo_slew_driver: RTL and testbench



---
 rtl/servo_slew_driver_if.sv | 28 ++
 rtl/servo_slew_driver.sv | 121 ++++++++++++
 tb/tb_servo_slew_driver.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_slew_driver_if.sv
// Bin input and servo output bundle for servo_slew_driver.
// The localizer side (master) drives bins; the driver (slave) returns PWM and status.
interface servo_slew_driver_if;
    logic [3:0]  bin_in;
    logic        bin_valid_in;
    logic        pwm_out;
    logic [3:0]  target_bin_out;
    logic [20:0] pulse_width_out;
    logic        settled_out;

    modport master (
        output bin_in,
        output bin_valid_in,
        input  pwm_out,
        input  target_bin_out,
        input  pulse_width_out,
        input  settled_out
    );

    modport slave (
        input  bin_in,
        input  bin_valid_in,
        output pwm_out,
        output target_bin_out,
        output pulse_width_out,
        output settled_out
    );
endinterface

// File: rtl/servo_slew_driver.sv
// Debounced direction bin -> rate-limited 50 Hz servo PWM.
// Define SERVO_SLEW_EN for slew-limited width changes; otherwise the width jumps at each boundary.
module servo_slew_driver #(
    parameter int unsigned PERIOD_CYCLES = 1966080,
    parameter int unsigned MIN_PULSE     = 98304,
    parameter int unsigned MAX_PULSE     = 196608,
    parameter int unsigned NUM_BINS      = 16,
    parameter int unsigned STABLE_COUNT  = 3,
    parameter int unsigned SLEW_STEP     = 4096,
    parameter int unsigned RESET_BIN     = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    servo_slew_driver_if.slave bus_if
);

    localparam int unsigned STEP_PER_BIN = (MAX_PULSE - MIN_PULSE) / (NUM_BINS - 1);

    localparam logic [20:0] L_MIN_W       = 21'(MIN_PULSE);
    localparam logic [20:0] L_STEP_W      = 21'(STEP_PER_BIN);
    localparam logic [20:0] L_PERIOD_LAST = 21'(PERIOD_CYCLES - 1);
    localparam logic [20:0] L_RESET_W     = 21'(MIN_PULSE + RESET_BIN * STEP_PER_BIN);
    localparam logic [4:0]  L_NUM_BINS    = 5'(NUM_BINS);
    localparam logic [3:0]  L_MAX_BIN     = 4'(NUM_BINS - 1);
    localparam logic [3:0]  L_STABLE      = 4'(STABLE_COUNT);
    localparam logic [3:0]  L_RESET_BIN   = 4'(RESET_BIN);
`ifdef SERVO_SLEW_EN
    localparam logic [20:0] L_SLEW        = 21'(SLEW_STEP);
`endif

    function automatic logic [20:0] width_of(input logic [3:0] b);
        return L_MIN_W + 21'(b) * L_STEP_W;
    endfunction

    logic [20:0] r_cnt;
    logic [20:0] r_active;
    logic [20:0] r_target_w;
    logic [3:0]  r_target_bin;
    logic [3:0]  r_cand;
    logic [3:0]  r_count;
    logic        r_pwm;
    logic        r_settled;

    logic [3:0]  w_bin_clamped;
    logic [3:0]  w_cand_d;
    logic [3:0]  w_count_d;
    logic [3:0]  w_target_bin_d;
    logic [20:0] w_target_w_d;
    logic        w_boundary;
    logic [20:0] w_cnt_d;
    logic [20:0] w_active_d;

    always_comb begin
        w_bin_clamped  = ({1'b0, bus_if.bin_in} >= L_NUM_BINS) ? L_MAX_BIN : bus_if.bin_in;
        w_cand_d       = r_cand;
        w_count_d      = r_count;
        w_target_bin_d = r_target_bin;
        w_target_w_d   = r_target_w;

        if (bus_if.bin_valid_in) begin
            if (w_bin_clamped == r_cand) begin
                if (r_count != L_STABLE) begin
                    w_count_d = r_count + 4'd1;
                end
            end else begin
                w_cand_d  = w_bin_clamped;
                w_count_d = 4'd1;
            end
            // Saturated count keeps re-asserting the same target, which is harmless.
            if (w_count_d == L_STABLE) begin
                w_target_bin_d = w_cand_d;
                w_target_w_d   = width_of(w_cand_d);
            end
        end

        w_boundary = (r_cnt == L_PERIOD_LAST);
        w_cnt_d    = w_boundary ? 21'd0 : r_cnt + 21'd1;

        // Slew uses the registered target, so a same-cycle target update waits a period.
        w_active_d = r_active;
        if (w_boundary) begin
`ifdef SERVO_SLEW_EN
            if (r_active < r_target_w) begin
                w_active_d = (r_target_w - r_active > L_SLEW) ? r_active + L_SLEW : r_target_w;
            end else if (r_active > r_target_w) begin
                w_active_d = (r_active - r_target_w > L_SLEW) ? r_active - L_SLEW : r_target_w;
            end
`else
            w_active_d = r_target_w;
`endif
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cnt        <= 21'd0;
            r_active     <= L_RESET_W;
            r_target_w   <= L_RESET_W;
            r_target_bin <= L_RESET_BIN;
            r_cand       <= L_RESET_BIN;
            r_count      <= 4'd0;
            r_pwm        <= 1'b0;
            r_settled    <= 1'b1;
        end else begin
            r_cnt        <= w_cnt_d;
            r_active     <= w_active_d;
            r_target_w   <= w_target_w_d;
            r_target_bin <= w_target_bin_d;
            r_cand       <= w_cand_d;
            r_count      <= w_count_d;
            r_pwm        <= (r_cnt < r_active);
            r_settled    <= (w_active_d == w_target_w_d);
        end
    end

    assign bus_if.pwm_out         = r_pwm;
    assign bus_if.target_bin_out  = r_target_bin;
    assign bus_if.pulse_width_out = r_active;
    assign bus_if.settled_out     = r_settled;

endmodule

// File: tb/tb_servo_slew_driver.sv
// Self-checking bench for servo_slew_driver: per-cycle model compare plus literal checkpoints.
// Expected slew values follow the SERVO_SLEW_EN setting of the build.
module tb_servo_slew_driver;

    localparam int PER    = 1000;
    localparam int MINP   = 100;
    localparam int MAXP   = 250;
    localparam int NB     = 16;
    localparam int STABLE = 3;
    localparam int SLEW   = 20;
    localparam int RBIN   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    servo_slew_driver_if u_if ();
    servo_slew_driver_if u_if12 ();

    servo_slew_driver #(
        .PERIOD_CYCLES(PER), .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .NUM_BINS(NB),
        .STABLE_COUNT(STABLE), .SLEW_STEP(SLEW), .RESET_BIN(RBIN)
    ) u_dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus_if(u_if)
    );

    servo_slew_driver #(
        .PERIOD_CYCLES(PER), .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .NUM_BINS(12),
        .STABLE_COUNT(STABLE), .SLEW_STEP(SLEW), .RESET_BIN(RBIN)
    ) u_dut12 (
        .clk_in(clk),
        .rst_in(rst),
        .bus_if(u_if12)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int w_of(input int b);
        return MINP + b * ((MAXP - MINP) / (NB - 1));
    endfunction

    // Behavioural model: filter = last STABLE valid bins identical; width moves once per period.
    int m_phase;
    int m_active;
    int m_target_bin;
    bit m_pwm;
    bit m_settled;
    int m_hist[$];
    bit m_check_en = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        int a;
        int t;
        int b;
        int wt;
        bit all_eq;
        if (rst) begin
            m_phase      <= 0;
            m_active     <= w_of(RBIN);
            m_target_bin <= RBIN;
            m_pwm        <= 1'b0;
            m_settled    <= 1'b1;
            m_hist.delete();
        end else begin
            a  = m_active;
            t  = m_target_bin;
            wt = w_of(t);
            if (m_phase == PER - 1) begin
`ifdef SERVO_SLEW_EN
                if (a < wt) a = (a + SLEW > wt) ? wt : a + SLEW;
                else if (a > wt) a = (a - SLEW < wt) ? wt : a - SLEW;
`else
                a = wt;
`endif
            end
            if (u_if.bin_valid_in) begin
                b = (int'(u_if.bin_in) >= NB) ? NB - 1 : int'(u_if.bin_in);
                m_hist.push_back(b);
                if (m_hist.size() > STABLE) void'(m_hist.pop_front());
                if (m_hist.size() == STABLE) begin
                    all_eq = 1'b1;
                    foreach (m_hist[i]) if (m_hist[i] != b) all_eq = 1'b0;
                    if (all_eq) t = b;
                end
            end
            m_pwm        <= (m_phase < m_active);
            m_active     <= a;
            m_target_bin <= t;
            m_settled    <= (a == w_of(t));
            m_phase      <= (m_phase + 1) % PER;
        end
    end

    always @(negedge clk) begin
        if (!rst && m_check_en) begin
            check("cyc_pwm", int'(u_if.pwm_out), int'(m_pwm));
            check("cyc_target_bin", int'(u_if.target_bin_out), m_target_bin);
            check("cyc_width", int'(u_if.pulse_width_out), m_active);
            check("cyc_settled", int'(u_if.settled_out), int'(m_settled));
        end
    end

    task automatic wait_phase(input int p);
        int guard = 0;
        while (m_phase != p) begin
            @(negedge clk);
            guard++;
            if (guard > 3 * PER) begin
                check("wait_phase_timeout", m_phase, p);
                return;
            end
        end
    endtask

    task automatic feed(input logic [3:0] b);
        u_if.bin_in       = b;
        u_if.bin_valid_in = 1'b1;
        @(negedge clk);
        u_if.bin_valid_in = 1'b0;
    endtask

    task automatic feed12(input logic [3:0] b);
        u_if12.bin_in       = b;
        u_if12.bin_valid_in = 1'b1;
        @(negedge clk);
        u_if12.bin_valid_in = 1'b0;
    endtask

    // Starts at phase 1 (first cycle pwm reflects counter 0) and spans one full period.
    task automatic count_period(output int n);
        n = 0;
        repeat (PER) begin
            if (u_if.pwm_out) n++;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pwm"}, int'(u_if.pwm_out), 0);
        check({tag, "_target"}, int'(u_if.target_bin_out), 8);
        check({tag, "_width"}, int'(u_if.pulse_width_out), 180);
        check({tag, "_settled"}, int'(u_if.settled_out), 1);
    endtask

    int n;
    int exp_w[4];

    initial begin
`ifdef SERVO_SLEW_EN
        exp_w = '{200, 220, 240, 250};
`else
        exp_w = '{250, 250, 250, 250};
`endif
        u_if.bin_in         = 4'd0;
        u_if.bin_valid_in   = 1'b0;
        u_if12.bin_in       = 4'd0;
        u_if12.bin_valid_in = 1'b0;

        // Reset
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        m_check_en = 1'b1;
        check_reset_vals("reset");
        check("model_reset_width", m_active, 180);

        // Clamp on a 12-bin instance: 14 -> 11
        feed12(4'd14);
        feed12(4'd14);
        feed12(4'd14);
        check("clamp12_target", int'(u_if12.target_bin_out), 11);

        wait_phase(1);
        count_period(n);
        check("reset_period_highs", n, 180);

        // Slew up toward bin 15
        wait_phase(5);
        feed(4'd15);
        feed(4'd15);
        feed(4'd15);
        check("up_target", int'(u_if.target_bin_out), 15);
        check("up_settled_drop", int'(u_if.settled_out), 0);
        wait_phase(1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("up_width_%0d", k), int'(u_if.pulse_width_out), exp_w[k]);
            check($sformatf("up_settled_%0d", k), int'(u_if.settled_out), int'(exp_w[k] == 250));
            count_period(n);
            check($sformatf("up_highs_%0d", k), n, exp_w[k]);
        end

        // Mid-period async reset while pwm is high
        wait_phase(100);
        check("pre_reset_pwm_high", int'(u_if.pwm_out), 1);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst_a");
        @(negedge clk);
        rst = 1'b0;
        wait_phase(400);
        check("pwm_at_400", int'(u_if.pwm_out), 0);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst_400");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_pwm_first", int'(u_if.pwm_out), 1);
        count_period(n);
        check("restart_highs", n, 180);

        // Filter 5,5,4,5,5,5
        feed(4'd5); @(negedge clk);
        feed(4'd5); @(negedge clk);
        feed(4'd4); @(negedge clk);
        feed(4'd5); @(negedge clk);
        feed(4'd5);
        check("filter_hold_target", int'(u_if.target_bin_out), 8);
        @(negedge clk);
        feed(4'd5);
        check("filter_accept_target", int'(u_if.target_bin_out), 5);
        check("filter_settled_drop", int'(u_if.settled_out), 0);
        repeat (7 * PER) @(negedge clk);
        check("filter_final_width", int'(u_if.pulse_width_out), 150);
        check("filter_final_settled", int'(u_if.settled_out), 1);

        // Final valid lands on the boundary cycle
        wait_phase(995);
        feed(4'd15);
        wait_phase(997);
        feed(4'd15);
        wait_phase(999);
        feed(4'd15);
        check("race_target", int'(u_if.target_bin_out), 15);
        check("race_width_held", int'(u_if.pulse_width_out), 150);
        check("race_settled", int'(u_if.settled_out), 0);
        wait_phase(999);
        @(negedge clk);
`ifdef SERVO_SLEW_EN
        check("race_width_next", int'(u_if.pulse_width_out), 170);
`else
        check("race_width_next", int'(u_if.pulse_width_out), 250);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
